// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data RAM between the pipeline MEM stage
//            and the debug unit. The pipeline has priority; debug is aged.
// Option   : DMEM_ARB_STATS_EN enables the conflict_cnt statistics counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 13,
  parameter int MAX_WAIT = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [31:0]   p_wdata,
  output logic [31:0]   p_rdata,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_PIPE = 2'd1,
    RD_DBG  = 2'd2
  } rd_owner_t;

  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  logic [CW-1:0] wait_q, wait_d;
  rd_owner_t     rd_owner_q, rd_owner_d;
  logic [31:0]   p_hold_q, p_hold_d;
  logic          force_dbg, own_pipe, own_dbg;

  // Nobody owns the RAM while reset is asserted, so all outputs sit at idle.
  always_comb begin
    force_dbg = 1'b0;
    own_pipe  = 1'b0;
    own_dbg   = 1'b0;
    if (!reset) begin
      force_dbg = d_req && (wait_q >= MAX_WAIT_C);
      own_dbg   = force_dbg || (d_req && !p_req);
      own_pipe  = p_req && !force_dbg;
    end
  end

  assign d_gnt   = own_dbg;
  assign p_stall = force_dbg && p_req;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = 32'h0;
    if (own_dbg) begin
      ram_we   = d_we;
      ram_addr = d_addr;
      ram_din  = d_wdata;
    end else if (own_pipe) begin
      ram_we   = p_we;
      ram_addr = p_addr;
      ram_din  = p_wdata;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (own_dbg) begin
      wait_d = '0;
    end else if (d_req && (wait_q < MAX_WAIT_C)) begin
      wait_d = wait_q + CW'(1);
    end

    rd_owner_d = RD_NONE;
    if (own_pipe && !p_we) begin
      rd_owner_d = RD_PIPE;
    end else if (own_dbg && !d_we) begin
      rd_owner_d = RD_DBG;
    end

    p_hold_d = (rd_owner_q == RD_PIPE) ? ram_dout : p_hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q     <= '0;
      rd_owner_q <= RD_NONE;
      p_hold_q   <= 32'h0;
    end else begin
      wait_q     <= wait_d;
      rd_owner_q <= rd_owner_d;
      p_hold_q   <= p_hold_d;
    end
  end

  // p_hold keeps the pipeline's last read visible across debug cycles.
  assign d_rvalid = !reset && (rd_owner_q == RD_DBG);
  assign d_rdata  = d_rvalid ? ram_dout : 32'h0;
  assign p_rdata  = reset ? 32'h0 : ((rd_owner_q == RD_PIPE) ? ram_dout : p_hold_q);

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (p_req && d_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 16'h0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = reset ? 16'h0 : conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int AW = 13;
  localparam int MW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_req, p_we, d_req, d_we;
  logic [AW-1:0] p_addr, d_addr;
  logic [31:0]   p_wdata, d_wdata;
  logic [31:0]   p_rdata, d_rdata, ram_din;
  logic          p_stall, d_gnt, d_rvalid, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_dout = 32'h0;
  logic [15:0]   conflict_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram [16];

  dmem_arbiter #(.AW(AW), .MAX_WAIT(MW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Small synchronous RAM; reloaded with a known pattern whenever reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'hA5A50000 + 32'(i);
    end else if (ram_we) begin
      ram[ram_addr[3:0]] <= ram_din;
    end
    ram_dout <= ram[ram_addr[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: age of the waiting debug request, pending read return,
  // last pipeline read value and a mirror of RAM contents.
  initial begin : model
    int          age, pend, conf;
    logic [31:0] pdata, last_pipe;
    logic [31:0] mmem [16];
    logic        r, pr, pw, dr, dw, e_dbg, e_pipe, e_stall, e_we, e_rv;
    logic [AW-1:0] pa, da, e_addr;
    logic [31:0] pd, dd, e_din, e_dr, e_pr;
    logic [15:0] e_conf;
    age = 0; pend = 0; conf = 0; pdata = 0; last_pipe = 0;
    for (int i = 0; i < 16; i++) mmem[i] = 32'hA5A50000 + 32'(i);
    forever begin
      @(negedge clk);
      r = reset; pr = p_req; pw = p_we; pa = p_addr; pd = p_wdata;
      dr = d_req; dw = d_we; da = d_addr; dd = d_wdata;
      e_dbg = 0; e_pipe = 0; e_stall = 0;
      if (!r) begin
        if (dr && age >= MW) begin e_dbg = 1; e_stall = pr; end
        else if (pr) e_pipe = 1;
        else if (dr) e_dbg = 1;
      end
      e_we   = e_dbg ? dw : (e_pipe ? pw : 1'b0);
      e_addr = e_dbg ? da : (e_pipe ? pa : '0);
      e_din  = e_dbg ? dd : (e_pipe ? pd : 32'h0);
      e_rv   = !r && pend == 2;
      e_dr   = e_rv ? pdata : 32'h0;
      e_pr   = r ? 32'h0 : (pend == 1 ? pdata : last_pipe);
`ifdef DMEM_ARB_STATS_EN
      e_conf = r ? 16'h0 : 16'(conf);
`else
      e_conf = 16'h0;
`endif
      chk("d_gnt", 32'(d_gnt), 32'(e_dbg));
      chk("p_stall", 32'(p_stall), 32'(e_stall));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_din", ram_din, e_din);
      chk("d_rvalid", 32'(d_rvalid), 32'(e_rv));
      chk("d_rdata", d_rdata, e_dr);
      chk("p_rdata", p_rdata, e_pr);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(e_conf));
      @(posedge clk);
      if (r) begin
        age = 0; pend = 0; last_pipe = 0; conf = 0;
        for (int i = 0; i < 16; i++) mmem[i] = 32'hA5A50000 + 32'(i);
      end else begin
        if (pend == 1) last_pipe = pdata;
        pend = 0;
        if (e_dbg || e_pipe) begin
          if (e_we) mmem[e_addr[3:0]] = e_din;
          else begin
            pend  = e_dbg ? 2 : 1;
            pdata = mmem[e_addr[3:0]];
          end
        end
        if (e_dbg) age = 0;
        else if (dr && age < MW) age++;
        if (pr && dr && conf < 65535) conf++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    logic g, s;
    reset = 1; p_req = 1; p_we = 0; p_addr = 13'd3; p_wdata = 32'h0;
    d_req = 1; d_we = 0; d_addr = 13'd4; d_wdata = 32'h0;

    // Reset held two cycles with both requesters active.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_p_stall", 32'(p_stall), 32'd0);
      chk("rst_p_rdata", p_rdata, 32'h0);
      if (i == 0) tick;
    end
    tick; reset = 0;
    @(negedge clk);
    chk("first_pipe_wins_gnt", 32'(d_gnt), 32'd0);
    chk("first_pipe_wins_addr", 32'(ram_addr), 32'd3);

    // Debug write then read of address 5 with the pipeline idle.
    tick; p_req = 0;
    tick; d_we = 1; d_addr = 13'd5; d_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("dbg_wr_gnt", 32'(d_gnt), 32'd1);
    tick; d_we = 0;
    @(negedge clk); chk("dbg_rd_gnt", 32'(d_gnt), 32'd1);
    tick; d_req = 0;
    @(negedge clk);
    chk("dbg_rvalid", 32'(d_rvalid), 32'd1);
    chk("dbg_rdata", d_rdata, 32'hDEADBEEF);

    // Pipeline writes and reads addr 7, then a debug read is aged and forced.
    tick; p_req = 1; p_we = 1; p_addr = 13'd7; p_wdata = 32'h12345678;
    tick; p_we = 0;
    tick; d_req = 1; d_we = 0; d_addr = 13'd5;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      chk("aging_gnt_low", 32'(d_gnt), 32'd0);
      chk("aging_p_rdata", p_rdata, 32'h12345678);
      tick;
    end
    @(negedge clk);
    chk("forced_gnt", 32'(d_gnt), 32'd1);
    chk("forced_stall", 32'(p_stall), 32'd1);
    chk("forced_p_rdata", p_rdata, 32'h12345678);
    tick; d_req = 0;
    @(negedge clk);
    chk("after_force_stall", 32'(p_stall), 32'd0);
    chk("after_force_addr", 32'(ram_addr), 32'd7);
    chk("after_force_p_rdata", p_rdata, 32'h12345678);
    chk("after_force_rdata", d_rdata, 32'hDEADBEEF);

    // Debug read granted, reset on the following cycle drops its return.
    tick; p_req = 0; d_req = 1; d_addr = 13'd5;
    @(negedge clk); chk("pre_rst_gnt", 32'(d_gnt), 32'd1);
    tick; d_req = 0; reset = 1;
    @(negedge clk); chk("rst_drop_rvalid", 32'(d_rvalid), 32'd0);
    tick; reset = 0;
    @(negedge clk); chk("post_rst_rvalid", 32'(d_rvalid), 32'd0);

    // Ten conflict cycles; aging restarted from zero after reset.
    tick; p_req = 1; p_we = 0; p_addr = 13'd2; d_req = 1; d_we = 0; d_addr = 13'd3;
    @(negedge clk); chk("post_rst_age_gnt", 32'(d_gnt), 32'd0);
    repeat (9) tick;
    tick; p_req = 0; d_req = 0;
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_10", 32'(conflict_cnt), 32'd10);
`else
    chk("conflict_off", 32'(conflict_cnt), 32'd0);
`endif

    // Randomized traffic honouring the hold-until-granted / hold-while-stalled rules.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g = d_gnt;
      s = p_stall;
      tick;
      reset = ($urandom_range(0, 63) == 0);
      if (!s) begin
        p_req   = ($urandom_range(0, 2) != 0);
        p_we    = 1'($urandom_range(0, 1));
        p_addr  = AW'($urandom_range(0, 15));
        p_wdata = $urandom;
      end
      if (!d_req || g) begin
        d_req   = ($urandom_range(0, 1) == 1);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the pipeline MEM stage (default owner) and the debug unit (memory load/dump over the debug link).
- Sits between the MEM stage and the data RAM instance; drives the RAM's we/addr/din and returns read data to the correct owner.
- Arbitration is fixed priority to the pipeline, with an aging counter. A debug request that has waited MAX_WAIT cycles is forced through, and the pipeline is stalled for one cycle.

Parameters:
- AW, 13, RAM word-address width.
- MAX_WAIT, 8, cycles a pending debug request may lose before it is forced. 0 means debug wins immediately whenever it requests.
- CW, 4, width of the aging counter. Must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  pipeline accesses memory this cycle.
- p_we  in  1  pipeline write enable.
- p_addr  in  AW  pipeline address.
- p_wdata  in  32  pipeline write data (already forwarded).
- p_rdata  out  32  read data returned to the pipeline.
- p_stall  out  1  pipeline must hold the MEM stage and its inputs this cycle.
- d_req  in  1  debug request. Held stable with d_we/d_addr/d_wdata until granted.
- d_we  in  1  debug write enable.
- d_addr  in  AW  debug address.
- d_wdata  in  32  debug write data.
- d_gnt  out  1  combinational; the debug access is performed at this clock edge.
- d_rvalid  out  1  one-cycle pulse; d_rdata is valid.
- d_rdata  out  32  read data returned to debug.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid 1 cycle after the address.
- conflict_cnt  out  16  statistics output (see Optional Feature).

Behaviour:
- The RAM port mux is combinational from the current-cycle owner. With no owner: ram_we=0, ram_addr=0, ram_din=0.
- Owner decision, evaluated each cycle:
  - force = d_req & (wait_cnt >= MAX_WAIT).
  - force: owner=DBG, d_gnt=1, p_stall=p_req.
  - else if p_req: owner=PIPE, d_gnt=0, p_stall=0.
  - else if d_req: owner=DBG, d_gnt=1.
  - else: no owner.
- wait_cnt (CW bits, registered):
  - Cleared to 0 on reset or on any cycle with d_gnt=1.
  - Incremented when d_req=1 and d_gnt=0.
  - Saturates at MAX_WAIT.
  - Holds otherwise.
- Read-return tracking: registered rd_owner ∈ {NONE, PIPE, DBG}.
  - Set to PIPE on a pipeline read (owner=PIPE & !p_we).
  - Set to DBG on a debug read (d_gnt & !d_we).
  - Set to NONE otherwise.
- Debug read return:
  - d_rvalid = (rd_owner==DBG), registered.
  - d_rdata = ram_dout when d_rvalid=1, else 0.
  - Latency from d_gnt to d_rvalid is exactly 1 cycle.
- Pipeline read return:
  - p_rdata = ram_dout when rd_owner==PIPE.
  - Otherwise p_rdata = p_hold, a register loaded with ram_dout on every cycle where rd_owner==PIPE.
  - A forced debug cycle therefore never corrupts the pipeline's last read value.
- Writes complete at the granting edge and produce no return pulse.
- The pipeline must keep p_req/p_we/p_addr/p_wdata stable while p_stall=1. The stalled access is re-arbitrated next cycle and wins, because wait_cnt was just cleared.
- Back-to-back debug requests with p_req idle are granted every cycle, giving a throughput of 1 access per cycle.
- Reset values: p_stall=0, d_gnt=0, d_rvalid=0, d_rdata=0, p_rdata=0, p_hold=0, wait_cnt=0, rd_owner=NONE, ram_we=0, conflict_cnt=0.
- Reset mid-operation: an in-flight debug read is dropped and no d_rvalid follows. A pending d_req restarts aging from 0.
- Address arithmetic: none. Addresses pass through unmodified, with no wrap handling inside the block.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: conflict_cnt is a 16-bit register.
  - Increments on every cycle with p_req & d_req, regardless of the winner.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: conflict_cnt is tied to 16'h0000, no counter logic is synthesized, and all other behaviour is identical.

Test Plan:
- Reset held 2 cycles while d_req=1 and p_req=1: all outputs at reset values, ram_we=0. After release, the pipeline wins the first cycle.
- p_req=0; debug write addr 5 data 32'hDEADBEEF, then debug read addr 5: d_gnt=1 on both cycles, d_rvalid=1 one cycle after the read grant, d_rdata=32'hDEADBEEF.
- MAX_WAIT=3; p_req=1 continuously, d_req read of addr 5 held: d_gnt=0 for 3 cycles, then d_gnt=1 with p_stall=1 for exactly one cycle. The following cycle has p_stall=0 and the pipeline owns the RAM.
- Pipeline read addr 7 (holds 32'h12345678), then a forced debug cycle: p_rdata stays 32'h12345678 through the stall and after it.
- Debug read granted, reset asserted the next cycle: d_rvalid stays 0, wait_cnt=0.
- With DMEM_ARB_STATS_EN: 10 cycles of p_req=d_req=1 gives conflict_cnt=10. Without the macro, conflict_cnt=0.
